// File: rtl/seq_restoring_div_pkg.sv
// Shared arithmetic definitions for the sequential restoring divider.
package seq_restoring_div_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/rcs.sv
// Ripple-borrow subtractor: diff = a - b - bin, bout set on underflow.
module rcs #(
    parameter int G = 8
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         bin,
    output logic [G-1:0] diff,
    output logic         bout
);

    logic br;

    always_comb begin
        diff = '0;
        br   = bin;
        for (int unsigned i = 0; i < G; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through rcs.
module seq_restoring_div
    import seq_restoring_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W);

    div_state_t    state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          bout;
    logic          restore;
    logic [W-1:0]  q_step;
    logic [W-1:0]  r_step;

    // Partial remainder always stays below the divisor, so its top bit is kept implicit.
    assign trial = {r_q, q_q[W-1]};

    rcs #(.G(W + 1)) u_sub (
        .a    (trial),
        .b    ({1'b0, d_q}),
        .bin  (1'b0),
        .diff (diff),
        .bout (bout)
    );

    // diff[W] is zero whenever bout is clear, so folding it in never changes the decision.
    assign restore = bout | diff[W];
    assign q_step  = {q_q[W-2:0], ~restore};
    assign r_step  = restore ? trial[W-1:0] : diff[W-1:0];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DONE;
                    quo_d   = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
